// File: rtl/regression_ctrl_pkg.sv
// Shared types and constants for the regression run controller: state encoding,
// divider-select codes and the per-state output decode.
package regression_ctrl_pkg;

    localparam int DIV_TIMEOUT_DEFAULT = 64;

    localparam logic DIV_SEL_MEAN = 1'b0;
    localparam logic DIV_SEL_COEF = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        P1,
        MSTART,
        MWAIT,
        P2,
        CSTART,
        CWAIT,
        EPOCH,
        DONE,
        ERR
    } state_t;

    // Moore outputs that depend on the state alone.
    typedef struct packed {
        logic ld_1;
        logic ld_2;
        logic cnt1;
        logic cnt2;
        logic clr_acc;
        logic acc_en;
        logic pass_sel;
        logic div_start;
        logic div_sel;
        logic busy;
        logic done;
        logic err;
    } ctrl_t;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            INIT: begin
                c.ld_1    = 1'b1;
                c.ld_2    = 1'b1;
                c.clr_acc = 1'b1;
                c.busy    = 1'b1;
            end
            P1: begin
                c.cnt1     = 1'b1;
                c.acc_en   = 1'b1;
                c.pass_sel = 1'b0;
                c.busy     = 1'b1;
            end
            MSTART: begin
                c.div_start = 1'b1;
                c.div_sel   = DIV_SEL_MEAN;
                c.busy      = 1'b1;
            end
            MWAIT: begin
                c.div_sel = DIV_SEL_MEAN;
                c.busy    = 1'b1;
            end
            P2: begin
                c.cnt1     = 1'b1;
                c.acc_en   = 1'b1;
                c.pass_sel = 1'b1;
                c.busy     = 1'b1;
            end
            CSTART: begin
                c.div_start = 1'b1;
                c.div_sel   = DIV_SEL_COEF;
                c.busy      = 1'b1;
            end
            CWAIT: begin
                c.div_sel = DIV_SEL_COEF;
                c.busy    = 1'b1;
            end
            EPOCH: begin
                c.cnt2    = 1'b1;
                c.ld_1    = 1'b1;
                c.clr_acc = 1'b1;
                c.busy    = 1'b1;
            end
            DONE: c.done = 1'b1;
            ERR:  c.err  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/div_watchdog.sv
// Divider wait counter: cleared when a division is launched, counts idle wait
// cycles and flags when the last permitted wait cycle has been reached.
module div_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int W = $clog2(TIMEOUT) + 1;

    logic [W-1:0] count_reg;

    assign timeout = (count_reg == W'(TIMEOUT - 1));

    // Saturates at the terminal value so the flag can never be missed by a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !timeout) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/regression_ctrl.sv
// Sequencer for the two-pass regression datapath: sum pass, mean division,
// deviation pass, coefficient division, repeated per epoch, with divider watchdog.
module regression_ctrl
    import regression_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic cout1,
    input  logic cout2,
    input  logic div_done,
    output logic ld_1,
    output logic ld_2,
    output logic cnt1,
    output logic cnt2,
    output logic clr_acc,
    output logic acc_en,
    output logic pass_sel,
    output logic div_start,
    output logic div_sel,
    output logic ld_mean,
    output logic ld_coef,
    output logic busy,
    output logic done,
    output logic err
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  out_reg;
    logic   wd_clr;
    logic   wd_en;
    logic   wd_timeout;

    // div_done wins over the watchdog, so an answer on the last allowed cycle is kept.
    assign wd_clr = (state_reg == MSTART) || (state_reg == CSTART);
    assign wd_en  = ((state_reg == MWAIT) || (state_reg == CWAIT)) && !div_done;

    div_watchdog #(
        .TIMEOUT(DIV_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .timeout(wd_timeout)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start) state_next = INIT;
            INIT:   state_next = P1;
            P1:     if (cout1) state_next = MSTART;
            MSTART: state_next = MWAIT;
            MWAIT: begin
                if (div_done)        state_next = P2;
                else if (wd_timeout) state_next = ERR;
            end
            P2:     if (cout1) state_next = CSTART;
            CSTART: state_next = CWAIT;
            CWAIT: begin
                if (div_done)        state_next = EPOCH;
                else if (wd_timeout) state_next = ERR;
            end
            EPOCH:  state_next = cout2 ? DONE : P1;
            DONE:   state_next = IDLE;
            ERR:    if (start) state_next = INIT;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= decode(state_next);
        end
    end

    assign ld_mean = (state_reg == MWAIT) && div_done;
    assign ld_coef = (state_reg == CWAIT) && div_done;

    // The sample index is reloaded in the same cycle the mean is captured.
    assign ld_1      = out_reg.ld_1 | ld_mean;
    assign ld_2      = out_reg.ld_2;
    assign cnt1      = out_reg.cnt1;
    assign cnt2      = out_reg.cnt2;
    assign clr_acc   = out_reg.clr_acc;
    assign acc_en    = out_reg.acc_en;
    assign pass_sel  = out_reg.pass_sel;
    assign div_start = out_reg.div_start;
    assign div_sel   = out_reg.div_sel;
    assign busy      = out_reg.busy;
    assign done      = out_reg.done;
    assign err       = out_reg.err;

endmodule
